// File: rtl/scan_sequencer.sv
// Channel-scan controller feeding a 3-to-8 decoder: steps through the enabled
// channels of a latched mask, holding each for dwell+1 cycles.
module scan_sequencer #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  single,
    input  logic [2**SEL_W-1:0]   mask,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [SEL_W-1:0]      sel,
    output logic                  sel_en,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap
);

    localparam int NCH = 2**SEL_W;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               sel_en_q, sel_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]     mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               single_q, single_d;
    logic [SEL_W:0]     nxt;

    function automatic logic [SEL_W-1:0] lowest_bit(input logic [NCH-1:0] m);
        lowest_bit = '0;
        for (int i = NCH-1; i >= 0; i--)
            if (m[i]) lowest_bit = i[SEL_W-1:0];
    endfunction

    // Returns {found, index} of the lowest set bit strictly above cur.
    function automatic logic [SEL_W:0] next_above(input logic [NCH-1:0] m,
                                                  input logic [SEL_W-1:0] cur);
        next_above = '0;
        for (int i = NCH-1; i >= 0; i--)
            if (m[i] && (i > int'(cur))) next_above = {1'b1, i[SEL_W-1:0]};
    endfunction

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        sel_en_d = sel_en_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        dwell_d  = dwell_q;
        single_d = single_q;
        nxt      = next_above(mask_q, sel_q);

        case (state_q)
            IDLE: begin
                sel_en_d = 1'b0;
                busy_d   = 1'b0;
                if (start && !stop && (mask != '0)) begin
                    mask_d   = mask;
                    dwell_d  = dwell;
                    single_d = single;
                    sel_d    = lowest_bit(mask);
                    cnt_d    = dwell;
                    sel_en_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (stop) begin
                    state_d  = IDLE;
                    sel_en_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (nxt[SEL_W]) begin
                    sel_d = nxt[SEL_W-1:0];
                    cnt_d = dwell_q;
                end else if (single_q) begin
                    state_d  = IDLE;
                    sel_en_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    // End of a continuous pass: restart from the lowest channel.
                    sel_d  = lowest_bit(mask_q);
                    cnt_d  = dwell_q;
                    wrap_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            sel_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            cnt_q    <= '0;
            mask_q   <= '0;
            dwell_q  <= '0;
            single_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            sel_en_q <= sel_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            dwell_q  <= dwell_d;
            single_q <= single_d;
        end
    end

    assign sel    = sel_q;
    assign sel_en = sel_en_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: expected output vectors are queued as
// stimulus is applied and compared one per clock after each rising edge.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       single = 1'b0;
    logic [7:0] mask = 8'h00;
    logic [7:0] dwell = 8'h00;
    logic [2:0] sel;
    logic       sel_en, busy, done, wrap;

    int tests = 0;
    int fails = 0;

    // {sel, sel_en, busy, done, wrap}
    typedef logic [6:0] exp_t;
    exp_t exp_q[$];

    scan_sequencer #(.SEL_W(3), .DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .single(single),
        .mask  (mask),
        .dwell (dwell),
        .sel   (sel),
        .sel_en(sel_en),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [2:0] s, input logic en, input logic b,
                        input logic d, input logic w, input int n = 1);
        for (int k = 0; k < n; k++) exp_q.push_back({s, en, b, d, w});
    endtask

    task automatic run(input string tag, input int n = 1);
        exp_t e, o;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            o = {sel, sel_en, busy, done, wrap};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $error("FAIL %s: observed=%b required=queued expectation (queue empty)", tag, o);
            end else begin
                e = exp_q.pop_front();
                assert (o === e) else begin
                    fails++;
                    $error("FAIL %s[%0d]: observed sel/en/busy/done/wrap=%b required=%b", tag, k, o, e);
                end
            end
        end
    endtask

    task automatic check_now(input string tag, input exp_t e);
        exp_t o;
        o = {sel, sel_en, busy, done, wrap};
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed sel/en/busy/done/wrap=%b required=%b", tag, o, e);
        end
    endtask

    initial begin
        // 1. reset
        repeat (3) @(posedge clk);
        #1;
        check_now("reset_held", 7'b0);
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 0, 0, 0, 0, 2);
        run("reset_release", 2);

        // 2. continuous full scan, dwell 0
        mask = 8'hFF; dwell = 8'd0; single = 1'b0; start = 1'b1;
        push(0, 1, 1, 0, 0);
        run("full_first");
        start = 1'b0;
        for (int i = 1; i < 8; i++) push(i[2:0], 1, 1, 0, 0);
        push(0, 1, 1, 0, 1);
        push(1, 1, 1, 0, 0);
        run("full_scan", 9);
        stop = 1'b1;
        push(1, 0, 0, 1, 0);
        run("full_stop");
        stop = 1'b0;
        push(1, 0, 0, 0, 0);
        run("full_idle");

        // 3. single pass, sparse mask, dwell 2
        mask = 8'b1010_0100; dwell = 8'd2; single = 1'b1; start = 1'b1;
        push(2, 1, 1, 0, 0);
        run("sparse_first");
        start = 1'b0;
        push(2, 1, 1, 0, 0, 2);
        push(5, 1, 1, 0, 0, 3);
        push(7, 1, 1, 0, 0, 3);
        push(7, 0, 0, 1, 0);
        run("sparse_pass", 9);
        // restart accepted in the same cycle done is high
        mask = 8'h01; dwell = 8'd0; single = 1'b1; start = 1'b1;
        push(0, 1, 1, 0, 0);
        run("restart_on_done");
        start = 1'b0;
        push(0, 0, 0, 1, 0);
        push(0, 0, 0, 0, 0);
        run("restart_pass", 2);

        // 4. stop mid-scan at sel=4, dwell 3, start alongside stop ignored
        mask = 8'hFF; dwell = 8'd3; single = 1'b0; start = 1'b1;
        push(0, 1, 1, 0, 0);
        run("stop_first");
        start = 1'b0;
        push(0, 1, 1, 0, 0, 3);
        push(1, 1, 1, 0, 0, 4);
        push(2, 1, 1, 0, 0, 4);
        push(3, 1, 1, 0, 0, 4);
        push(4, 1, 1, 0, 0);
        run("stop_scan", 16);
        stop = 1'b1; start = 1'b1;
        push(4, 0, 0, 1, 0);
        run("stop_done");
        push(4, 0, 0, 0, 0);
        run("stop_wins_idle");
        stop = 1'b0; start = 1'b0;
        push(4, 0, 0, 0, 0);
        run("stop_idle");

        // 5. ignored starts
        mask = 8'h00; start = 1'b1;
        push(4, 0, 0, 0, 0, 2);
        run("zero_mask", 2);
        mask = 8'b0000_0110; dwell = 8'd0; single = 1'b0;
        push(1, 1, 1, 0, 0);
        run("busy_first");
        mask = 8'h01; dwell = 8'd5; single = 1'b1;
        push(2, 1, 1, 0, 0);
        push(1, 1, 1, 0, 1);
        push(2, 1, 1, 0, 0);
        push(1, 1, 1, 0, 1);
        run("busy_start_ignored", 4);
        start = 1'b0; stop = 1'b1;
        push(1, 0, 0, 1, 0);
        run("busy_stop");
        stop = 1'b0;

        // 6. single channel continuous, dwell 1
        mask = 8'b0001_0000; dwell = 8'd1; single = 1'b0; start = 1'b1;
        push(4, 1, 1, 0, 0);
        run("one_ch_first");
        start = 1'b0;
        push(4, 1, 1, 0, 0);
        push(4, 1, 1, 0, 1);
        push(4, 1, 1, 0, 0);
        push(4, 1, 1, 0, 1);
        push(4, 1, 1, 0, 0);
        run("one_ch_wrap", 5);

        // 1b. asynchronous reset mid-scan, no done afterwards
        rst_n = 1'b0;
        #1;
        check_now("async_reset", 7'b0);
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 0, 0, 0, 0, 2);
        run("post_reset", 2);

        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL queue_drain: observed=%0d leftover required=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
Sequential channel-scan controller that drives the 3-to-8 decoder stage directly. It produces a 3-bit channel index (sel) and a decoder enable (sel_en). It steps through a masked subset of the 8 channels and holds each one for a programmable dwell time. It supports continuous or single-pass scanning, with start/stop control and status pulses.

Parameters:
SEL_W, 3, width of channel index; channel count is 2**SEL_W = 8
DWELL_W, 8, width of dwell count

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level, sampled each edge; begins a scan when idle
stop  input  1  level, sampled each edge; aborts an active scan
single  input  1  sampled with start; 1 = one pass, 0 = continuous
mask  input  8  sampled with start; bit i = 1 enables channel i
dwell  input  DWELL_W  sampled with start; each channel is held dwell+1 cycles
sel  output  SEL_W  registered channel index to the decoder 'in'
sel_en  output  1  registered enable to the decoder 'en'
busy  output  1  high while a scan is active
done  output  1  1-cycle pulse when a scan ends (pass complete or stopped)
wrap  output  1  1-cycle pulse on the first cycle of each new continuous pass

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; sel = 0, sel_en = 0, busy = 0, done = 0, wrap = 0.
  - Internal counter and latched mask/dwell/single are cleared.
  - Reset asserted mid-scan takes effect immediately, with no done pulse.
- States: IDLE, SCAN. All outputs are registered; there are no combinational paths from inputs to outputs.
- Default each cycle: done = 0, wrap = 0.
- IDLE:
  - sel_en = 0, busy = 0, and sel holds its last value.
  - start = 1, stop = 0, mask != 0:
    - Latch mask, dwell and single.
    - Load sel = index of the lowest set bit of mask, and cnt = dwell.
    - Set sel_en = 1, busy = 1, and go to SCAN.
    - sel/sel_en are visible in the cycle after start is sampled (1-cycle latency).
  - start with mask == 0: ignored; stay in IDLE with no pulse.
  - start and stop both high: stop wins; stay in IDLE.
- SCAN, per cycle:
  - stop = 1 (highest priority): next cycle IDLE, sel_en = 0, busy = 0, done = 1, sel holds.
  - Otherwise, if cnt != 0: cnt decrements; sel is unchanged.
  - Otherwise (cnt == 0), advance: the next channel is the next set bit of the latched mask strictly above sel, searched in increasing index.
    - If one exists: sel = that index, cnt = latched dwell.
    - If none exists (end of pass) and single = 1: next cycle IDLE, sel_en = 0, busy = 0, done = 1, sel holds the last channel.
    - If none exists and single = 0: sel = lowest set bit of the latched mask, cnt = latched dwell, wrap = 1 in the first cycle of the new pass.
- Only one enabled channel in continuous mode: sel stays constant; wrap pulses every dwell+1 cycles.
- start while busy: ignored. Changes to mask, dwell or single during SCAN have no effect until the next start.
- Dwell arithmetic: unsigned. dwell = 0 gives 1 cycle per channel; dwell = 255 gives 256 cycles. There is no overflow, because cnt only counts down.
- sel_en = 1 exactly when busy = 1. The downstream decoder output is therefore one-hot during a scan and all-zero when idle.
- After done, a new start is accepted in the first IDLE cycle (the same cycle done is high).

Test Plan:
1. Reset: hold rst_n low, then release with start = 0 -> sel = 0, sel_en = 0, busy = 0, done = 0, wrap = 0; assert rst_n low mid-scan -> all outputs clear asynchronously, with no done pulse.
2. Continuous full scan: mask = 8'hFF, dwell = 0, single = 0, pulse start -> one cycle later sel steps 0,1,...,7,0,1 one per cycle with sel_en = 1; wrap = 1 only in the cycle where sel returns to 0.
3. Single pass, sparse mask: mask = 8'b1010_0100, dwell = 2, single = 1 -> sel = 2 for 3 cycles, 5 for 3 cycles, 7 for 3 cycles; next cycle sel_en = 0, busy = 0, done = 1 for 1 cycle, sel = 7.
4. Stop mid-scan: mask = 8'hFF, dwell = 3, stop asserted while sel = 4 -> next cycle sel_en = 0, busy = 0, done = 1, sel = 4; a start in the same cycle as stop is ignored.
5. Ignored starts: start with mask = 0 -> stays IDLE with no done; start during SCAN with new mask = 8'h01 -> scan continues on the original mask.
6. Single channel, continuous: mask = 8'b0001_0000, dwell = 1 -> sel = 4 constantly, sel_en = 1, wrap pulses every 2 cycles.
